time_entry_ctrl: RTL and testbench
==================================

Name: time_entry_ctrl

Overview:
Keypad sequencing controller for the alarm clock.
- Collects up to four BCD digits into an entry buffer and validates the result as an HH:MM time.
- Commits the buffer to either the current-time counter (load_new_c) or the alarm register (load_new_a).
- Drives the display-select flags and times out abandoned entries.
- Sits between the keypad decoder and the time counter / alarm register; its buffer outputs feed both.

Parameters:
TIMEOUT_SEC, 10, number of one_second pulses without an accepted key before KEY_ENTRY or SHOW_ALARM aborts to SHOW_TIME.
TIMER_W, 4, width of the timeout counter; must hold TIMEOUT_SEC.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
one_second  input  1  one-cycle pulse, once per second.
key_valid  input  1  one-cycle strobe per key press.
key_code  input  4  0-9 digit; 4'hA ALARM; 4'hB TIME; 4'hC-4'hF ignored.
key_buffer_ms_hr  output  4  entry buffer, hours tens digit.
key_buffer_ls_hr  output  4  entry buffer, hours units digit.
key_buffer_ms_min  output  4  entry buffer, minutes tens digit.
key_buffer_ls_min  output  4  entry buffer, minutes units digit.
load_new_c  output  1  one-cycle pulse: load the buffer into the time counter.
load_new_a  output  1  one-cycle pulse: load the buffer into the alarm register.
show_new_time  output  1  display should show the entry buffer.
show_a  output  1  display should show the alarm time.
entry_error  output  1  one-cycle pulse: commit rejected.

Behaviour:
- Reset (async, active-high):
  - State goes to SHOW_TIME.
  - Buffer 0000, digit count 0, timer 0.
  - All outputs 0.
- All outputs are registered.
- States: SHOW_TIME, KEY_ENTRY, SHOW_ALARM, LOAD_TIME, LOAD_ALARM.
- Digit shift (digit key): ms_hr<=ls_hr, ls_hr<=ms_min, ms_min<=ls_min, ls_min<=digit. Digit count increments and saturates at 4; a 5th or later digit still shifts.
- Accepted key: key_valid=1 and key_code 0-B. Codes C-F are ignored entirely: no state change, no timer clear.
- SHOW_TIME:
  - Digit: clear buffer, shift digit in (buffer 000d), count=1, go to KEY_ENTRY.
  - ALARM: go to SHOW_ALARM.
  - TIME: ignored.
- KEY_ENTRY, show_new_time=1:
  - Digit: shift.
  - TIME: if count==4 and buffer valid, go to LOAD_TIME. Otherwise pulse entry_error, clear buffer and count, go to SHOW_TIME.
  - ALARM: same rule, with LOAD_ALARM as the success target.
- Valid buffer means all of: ms_hr<=2; ls_hr<=9; ls_hr<=3 when ms_hr==2; ms_min<=5; ls_min<=9.
- LOAD_TIME: load_new_c=1 for exactly one cycle, buffer held stable; next state SHOW_TIME. Buffer and count clear on exit.
- LOAD_ALARM: identical, with load_new_a.
- Commit latency: the TIME/ALARM key sampled at edge N gives load pulse high from N to N+1. The consumer loads at edge N+1.
- Keys arriving during LOAD_TIME or LOAD_ALARM are dropped.
- SHOW_ALARM, show_a=1: any accepted key returns to SHOW_TIME; the key is consumed, not reinterpreted.
- Timeout:
  - The timer runs only in KEY_ENTRY and SHOW_ALARM. It increments on one_second and clears on each accepted key and on every state change.
  - When the timer reaches TIMEOUT_SEC: go to SHOW_TIME, clear buffer and count. No entry_error, no load.
  - key_valid and one_second in the same cycle: the key wins and the timer clears.
- Output flags in SHOW_TIME: show_new_time and show_a are both 0.
- Mutual exclusion: load_new_c and load_new_a are never high together. show_new_time and show_a are never high together.
- Reset mid-entry or mid-load aborts immediately; no load pulse is emitted afterwards.

Test Plan:
- Keys 1,2,3,4 then TIME → show_new_time=1 during entry; buffer 1234; load_new_c high exactly one cycle, one cycle after the TIME key; then SHOW_TIME with buffer 0000.
- Keys 0,7,3,0 then ALARM → load_new_a one-cycle pulse with buffer 0730; load_new_c stays 0.
- Keys 2,4,0,0 then TIME → entry_error pulse, no load. Keys 2,3,5,9 then TIME → load_new_c. Keys 1,2 then TIME → entry_error.
- Keys 1,2,3,4,5,6 then TIME → buffer 3456 → entry_error (ms_hr=3).
- Key 5, then 10 one_second pulses with no key → SHOW_TIME at the 10th pulse, buffer 0000, no error. Repeat with a digit on the same cycle as the 9th pulse → still KEY_ENTRY after the 10th pulse.
- ALARM → show_a=1; key 4'hD → show_a stays 1. Digit 8 → show_a=0, buffer unchanged.
- Reset asserted mid-entry (buffer 0012) → all outputs 0 asynchronously; a subsequent TIME key is ignored.

Source files
------------

// File: rtl/time_entry_ctrl_if.sv
// Keypad-to-controller bus for the alarm clock time-entry block.
// The master side is the keypad/timebase; the slave side is the controller.
interface time_entry_ctrl_if;
  logic       one_second;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] key_buffer_ms_hr;
  logic [3:0] key_buffer_ls_hr;
  logic [3:0] key_buffer_ms_min;
  logic [3:0] key_buffer_ls_min;
  logic       load_new_c;
  logic       load_new_a;
  logic       show_new_time;
  logic       show_a;
  logic       entry_error;

  modport master (
    output one_second, key_valid, key_code,
    input  key_buffer_ms_hr, key_buffer_ls_hr, key_buffer_ms_min, key_buffer_ls_min,
    input  load_new_c, load_new_a, show_new_time, show_a, entry_error
  );

  modport slave (
    input  one_second, key_valid, key_code,
    output key_buffer_ms_hr, key_buffer_ls_hr, key_buffer_ms_min, key_buffer_ls_min,
    output load_new_c, load_new_a, show_new_time, show_a, entry_error
  );
endinterface

// File: rtl/time_entry_ctrl.sv
// Keypad sequencing controller: gathers four BCD digits, validates HH:MM,
// and commits to the time counter or alarm register, with an idle timeout.
module time_entry_ctrl #(
  parameter int TIMEOUT_SEC = 10,
  parameter int TIMER_W     = 4
) (
  input  logic            clk,
  input  logic            reset,
  time_entry_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    SHOW_TIME, KEY_ENTRY, SHOW_ALARM, LOAD_TIME, LOAD_ALARM
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        buf_q, buf_d;       // {ms_hr, ls_hr, ms_min, ls_min}
  logic [2:0]         cnt_q, cnt_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               err_d;
  logic               err_q, load_c_q, load_a_q, show_new_q, show_a_q;

  logic accepted, is_digit, is_alarm, is_time, timeout;

  function automatic logic buf_valid(input logic [15:0] b);
    logic [3:0] mh, lh, mm, lm;
    {mh, lh, mm, lm} = b;
    return (mh <= 4'd2) && (lh <= 4'd9) && !((mh == 4'd2) && (lh > 4'd3)) &&
           (mm <= 4'd5) && (lm <= 4'd9);
  endfunction

  always_comb begin
    accepted = bus.key_valid && (bus.key_code <= 4'hB);
    is_digit = bus.key_code <= 4'd9;
    is_alarm = bus.key_code == 4'hA;
    is_time  = bus.key_code == 4'hB;
    timeout  = bus.one_second && (timer_q == TIMER_W'(TIMEOUT_SEC - 1));
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    timer_d = timer_q;
    case (state_q)
      SHOW_TIME: begin
        if (accepted && is_digit) begin
          buf_d   = {12'h000, bus.key_code};
          cnt_d   = 3'd1;
          state_d = KEY_ENTRY;
        end else if (accepted && is_alarm) begin
          state_d = SHOW_ALARM;
        end
      end
      KEY_ENTRY: begin
        if (accepted && is_digit) begin
          buf_d = {buf_q[11:0], bus.key_code};
          cnt_d = (cnt_q == 3'd4) ? 3'd4 : cnt_q + 3'd1;
        end else if (accepted) begin
          if ((cnt_q == 3'd4) && buf_valid(buf_q)) begin
            state_d = is_time ? LOAD_TIME : LOAD_ALARM;
          end else begin
            err_d   = 1'b1;
            buf_d   = 16'h0000;
            cnt_d   = 3'd0;
            state_d = SHOW_TIME;
          end
        end else if (timeout) begin
          buf_d   = 16'h0000;
          cnt_d   = 3'd0;
          state_d = SHOW_TIME;
        end
      end
      SHOW_ALARM: begin
        // Any accepted key only dismisses the alarm view.
        if (accepted) begin
          state_d = SHOW_TIME;
        end else if (timeout) begin
          buf_d   = 16'h0000;
          cnt_d   = 3'd0;
          state_d = SHOW_TIME;
        end
      end
      LOAD_TIME, LOAD_ALARM: begin
        buf_d   = 16'h0000;
        cnt_d   = 3'd0;
        state_d = SHOW_TIME;
      end
      default: state_d = SHOW_TIME;
    endcase

    if ((state_q != KEY_ENTRY && state_q != SHOW_ALARM) || accepted || (state_d != state_q))
      timer_d = '0;
    else if (bus.one_second)
      timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SHOW_TIME;
      buf_q      <= 16'h0000;
      cnt_q      <= 3'd0;
      timer_q    <= '0;
      err_q      <= 1'b0;
      load_c_q   <= 1'b0;
      load_a_q   <= 1'b0;
      show_new_q <= 1'b0;
      show_a_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      load_c_q   <= (state_d == LOAD_TIME);
      load_a_q   <= (state_d == LOAD_ALARM);
      show_new_q <= (state_d == KEY_ENTRY);
      show_a_q   <= (state_d == SHOW_ALARM);
    end
  end

  assign bus.key_buffer_ms_hr  = buf_q[15:12];
  assign bus.key_buffer_ls_hr  = buf_q[11:8];
  assign bus.key_buffer_ms_min = buf_q[7:4];
  assign bus.key_buffer_ls_min = buf_q[3:0];
  assign bus.load_new_c        = load_c_q;
  assign bus.load_new_a        = load_a_q;
  assign bus.show_new_time     = show_new_q;
  assign bus.show_a            = show_a_q;
  assign bus.entry_error       = err_q;

endmodule

// File: tb/tb_time_entry_ctrl.sv
// Directed self-checking bench for time_entry_ctrl.
module tb_time_entry_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  time_entry_ctrl_if bus ();

  time_entry_ctrl #(.TIMEOUT_SEC(10), .TIMER_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] buf_now();
    return {bus.key_buffer_ms_hr, bus.key_buffer_ls_hr,
            bus.key_buffer_ms_min, bus.key_buffer_ls_min};
  endfunction

  // flags = {show_new_time, show_a, load_new_c, load_new_a, entry_error}
  function automatic logic [4:0] flags();
    return {bus.show_new_time, bus.show_a, bus.load_new_c, bus.load_new_a, bus.entry_error};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] c);
    bus.key_valid = 1'b1;
    bus.key_code  = c;
    tick();
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  task automatic pulse(input bit with_key, input logic [3:0] c);
    bus.one_second = 1'b1;
    bus.key_valid  = with_key;
    bus.key_code   = c;
    tick();
    bus.one_second = 1'b0;
    bus.key_valid  = 1'b0;
    bus.key_code   = 4'h0;
    tick();
  endtask

  task automatic keys(input logic [3:0] k[$]);
    foreach (k[i]) key(k[i]);
  endtask

  initial begin
    bus.one_second = 1'b0;
    bus.key_valid  = 1'b0;
    bus.key_code   = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", 32'(flags()), 32'h0);
    check("reset_buf", 32'(buf_now()), 32'h0);
    reset = 1'b0;
    tick();

    // 1234 TIME
    key(4'd1);
    check("entry_show_new", 32'(flags()), 32'b10000);
    keys('{4'd2, 4'd3, 4'd4});
    check("entry_buf_1234", 32'(buf_now()), 32'h1234);
    key(4'hB);
    check("load_c_flags", 32'(flags()), 32'b00100);
    check("load_c_buf", 32'(buf_now()), 32'h1234);
    tick();
    check("after_load_c_flags", 32'(flags()), 32'b00000);
    check("after_load_c_buf", 32'(buf_now()), 32'h0);

    // 0730 ALARM
    keys('{4'd0, 4'd7, 4'd3, 4'd0});
    key(4'hA);
    check("load_a_flags", 32'(flags()), 32'b00010);
    check("load_a_buf", 32'(buf_now()), 32'h0730);
    tick();
    check("after_load_a_flags", 32'(flags()), 32'b00000);

    // 2400 invalid hour
    keys('{4'd2, 4'd4, 4'd0, 4'd0});
    key(4'hB);
    check("err_2400_flags", 32'(flags()), 32'b00001);
    check("err_2400_buf", 32'(buf_now()), 32'h0);
    tick();
    check("err_pulse_one_cycle", 32'(flags()), 32'b00000);

    // 2359 boundary valid
    keys('{4'd2, 4'd3, 4'd5, 4'd9});
    key(4'hB);
    check("load_2359_flags", 32'(flags()), 32'b00100);
    check("load_2359_buf", 32'(buf_now()), 32'h2359);
    tick();

    // too few digits
    keys('{4'd1, 4'd2});
    key(4'hB);
    check("err_short_flags", 32'(flags()), 32'b00001);
    tick();

    // six digits shift to 3456, ignored code in between
    keys('{4'd1, 4'd2, 4'd3, 4'hE, 4'd4, 4'd5, 4'd6});
    check("shift_buf_3456", 32'(buf_now()), 32'h3456);
    key(4'hB);
    check("err_3456_flags", 32'(flags()), 32'b00001);
    tick();

    // timeout after 10 pulses
    key(4'd5);
    for (int i = 0; i < 9; i++) pulse(1'b0, 4'h0);
    check("pre_timeout_flags", 32'(flags()), 32'b10000);
    pulse(1'b0, 4'h0);
    check("timeout_flags", 32'(flags()), 32'b00000);
    check("timeout_buf", 32'(buf_now()), 32'h0);

    // key on the 9th pulse restarts the timer
    key(4'd5);
    for (int i = 0; i < 8; i++) pulse(1'b0, 4'h0);
    pulse(1'b1, 4'd5);
    pulse(1'b0, 4'h0);
    check("timer_restart_flags", 32'(flags()), 32'b10000);
    check("timer_restart_buf", 32'(buf_now()), 32'h0055);
    key(4'hB);
    check("err_after_restart", 32'(flags()), 32'b00001);
    tick();

    // alarm view
    key(4'hA);
    check("show_a_on", 32'(flags()), 32'b01000);
    key(4'hD);
    check("show_a_ignored_key", 32'(flags()), 32'b01000);
    key(4'd8);
    check("show_a_off", 32'(flags()), 32'b00000);
    check("show_a_buf_kept", 32'(buf_now()), 32'h0);

    // async reset mid-entry
    keys('{4'd1, 4'd2});
    check("pre_reset_buf", 32'(buf_now()), 32'h0012);
    #2 reset = 1'b1;
    #1;
    check("async_reset_flags", 32'(flags()), 32'b00000);
    check("async_reset_buf", 32'(buf_now()), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    key(4'hB);
    check("time_after_reset", 32'(flags()), 32'b00000);
    tick();
    check("no_load_after_reset", 32'(flags()), 32'b00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
